// File: rtl/cond_branch_pred.sv
// cond_branch_pred: condition evaluation, 2-bit BHT direction prediction and resolve statistics.
module cond_branch_pred #(
    parameter int         N          = 32,
    parameter int         PC_W       = 32,
    parameter int         BHT_DEPTH  = 16,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             res_req,
    input  logic [PC_W-1:0]  res_pc,
    input  logic             res_pred,
    input  logic [N-1:0]     A,
    input  logic [2:0]       cond,
    output logic             res_valid,
    output logic             branch,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_bht [BHT_DEPTH];
    logic             r_pred_valid, r_pred_taken, r_res_valid, r_branch, r_mispredict;
    logic [CNT_W-1:0] r_branch_count, r_mispred_count;
    logic [IDX_W-1:0] w_pidx, w_ridx;
    logic             w_neg, w_zero, w_taken, w_cond, w_mis;
    logic [1:0]       w_cur, w_next;

    assign w_pidx  = pred_pc[IDX_W+1:2];
    assign w_ridx  = res_pc[IDX_W+1:2];
    assign w_neg   = A[N-1];
    assign w_zero  = (A == '0);
    assign w_cond  = cond inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
    assign w_taken = cond == 3'b100 ? 1'b1 :
                     cond == 3'b001 ? ~w_neg :
                     cond == 3'b010 ? w_neg :
                     cond == 3'b011 ? w_zero :
                     cond == 3'b101 ? ~w_zero :
                     cond == 3'b110 ? ~w_neg & ~w_zero : 1'b0;
    assign w_mis   = w_taken != res_pred;
    assign w_cur   = r_bht[w_ridx];
    assign w_next  = w_taken ? (w_cur == 2'b11 ? w_cur : w_cur + 2'b01)
                             : (w_cur == 2'b00 ? w_cur : w_cur - 2'b01);

    // Prediction reads the table before this edge's update lands (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= INIT_STATE;
            r_pred_valid    <= 1'b0;
            r_pred_taken    <= 1'b0;
            r_res_valid     <= 1'b0;
            r_branch        <= 1'b0;
            r_mispredict    <= 1'b0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else begin
            r_pred_valid <= pred_req;
            if (pred_req) r_pred_taken <= r_bht[w_pidx][1];
            r_res_valid  <= res_req;
            r_mispredict <= res_req & w_mis;
            if (res_req) r_branch <= w_taken;
            if (res_req && w_cond) begin
                r_bht[w_ridx] <= w_next;
                if (r_branch_count != '1) r_branch_count <= r_branch_count + 1'b1;
                if (w_mis && r_mispred_count != '1) r_mispred_count <= r_mispred_count + 1'b1;
            end
        end
    end

    assign pred_valid    = r_pred_valid;
    assign pred_taken    = r_pred_taken;
    assign res_valid     = r_res_valid;
    assign branch        = r_branch;
    assign mispredict    = r_mispredict;
    assign branch_count  = r_branch_count;
    assign mispred_count = r_mispred_count;
endmodule

// File: tb/tb_cond_branch_pred.sv
// tb_cond_branch_pred: scoreboarded reference model plus condition table for cond_branch_pred.
module tb_cond_branch_pred;
    localparam int CW = 4;

    logic          clk = 1'b0, rst, pred_req, res_req, res_pred;
    logic [31:0]   pred_pc, res_pc, A;
    logic [2:0]    cond;
    logic          pred_valid, pred_taken, res_valid, branch, mispredict;
    logic [CW-1:0] branch_count, mispred_count;

    cond_branch_pred #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .res_req(res_req),
        .res_pc(res_pc), .res_pred(res_pred), .A(A), .cond(cond),
        .res_valid(res_valid), .branch(branch), .mispredict(mispredict),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pv, pt, rv, br, mp;
        logic [CW-1:0] bc, mc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  c;
        logic        br;
    } vec_t;

    exp_t          q[$];
    logic [1:0]    m_bht [16];
    logic          m_pt, m_br;
    logic [CW-1:0] m_bc, m_mc;
    int            n_pass = 0, n_tot = 0;

    function automatic logic dec(input logic [31:0] a, input logic [2:0] c);
        case (c)
            3'b001:  return $signed(a) >= 0;
            3'b010:  return $signed(a) < 0;
            3'b011:  return a == 0;
            3'b100:  return 1'b1;
            3'b101:  return a != 0;
            3'b110:  return $signed(a) > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input logic r, input logic p, input logic [31:0] ppc, input logic rq,
                       input logic [31:0] rpc, input logic rp, input logic [31:0] a, input logic [2:0] c);
        exp_t e;
        logic tk;
        @(negedge clk);
        rst = r; pred_req = p; pred_pc = ppc; res_req = rq; res_pc = rpc; res_pred = rp; A = a; cond = c;
        if (r) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
            m_pt = 0; m_br = 0; m_bc = 0; m_mc = 0;
            e = '{0, 0, 0, 0, 0, 0, 0};
        end else begin
            e.pv = p;
            if (p) m_pt = m_bht[ppc[5:2]][1];
            e.rv = rq;
            e.mp = 0;
            if (rq) begin
                tk = dec(a, c);
                m_br = tk;
                e.mp = tk != rp;
                if (c inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110}) begin
                    if (tk && m_bht[rpc[5:2]] != 2'b11) m_bht[rpc[5:2]]++;
                    if (!tk && m_bht[rpc[5:2]] != 2'b00) m_bht[rpc[5:2]]--;
                    if (m_bc != '1) m_bc++;
                    if (e.mp && m_mc != '1) m_mc++;
                end
            end
            e.pt = m_pt; e.br = m_br; e.bc = m_bc; e.mc = m_mc;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("pred_valid", pred_valid, e.pv);
        chk("pred_taken", pred_taken, e.pt);
        chk("res_valid", res_valid, e.rv);
        chk("branch", branch, e.br);
        chk("mispredict", mispredict, e.mp);
        chk("branch_count", branch_count, e.bc);
        chk("mispred_count", mispred_count, e.mc);
    endtask

    task automatic pred(input logic [31:0] pc);
        cyc(0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic res(input logic [31:0] pc, input logic rp, input logic [31:0] a, input logic [2:0] c);
        cyc(0, 0, 0, 1, pc, rp, a, c);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 3'b010, 1};
        tbl[1] = '{32'hFFFF_FFFF, 3'b001, 0};
        tbl[2] = '{32'hFFFF_FFFF, 3'b110, 0};
        tbl[3] = '{32'hFFFF_FFFF, 3'b101, 1};
        tbl[4] = '{32'd5,         3'b110, 1};
        tbl[5] = '{32'd5,         3'b011, 0};
        tbl[6] = '{32'd5,         3'b000, 0};
        tbl[7] = '{32'd0,         3'b111, 0};
        tbl[8] = '{32'd0,         3'b100, 1};
        tbl[9] = '{32'h8000_0000, 3'b001, 0};

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        pred(32'h40);
        chk("init_pred_taken", pred_taken, 0);

        repeat (3) res(32'h40, 0, 0, 3'b011);
        pred(32'h40);
        chk("trained_pred_taken", pred_taken, 1);
        chk("bc_after_3", branch_count, 3);
        chk("mc_after_3", mispred_count, 3);

        for (int i = 0; i < 10; i++) begin
            res(32'h104, 0, tbl[i].a, tbl[i].c);
            chk($sformatf("sweep%0d", i), branch, tbl[i].br);
        end

        res(32'h10C, 0, 0, 3'b100);
        chk("uncond_mis", mispredict, 1);
        res(32'h10C, 0, 0, 3'b100);
        pred(32'h10C);
        chk("uncond_bht_kept", pred_taken, 0);

        repeat (19) res(32'h44, 1, 0, 3'b010);
        chk("bc_sat", branch_count, 4'hF);
        chk("mc_sat", mispred_count, 4'hF);

        cyc(1, 0, 0, 1, 32'h40, 0, 0, 3'b011);
        pred(32'h40);
        chk("reset_bht_init", pred_taken, 0);

        cyc(0, 1, 32'h80, 1, 32'h80, 0, 0, 3'b011);
        chk("rbw_old_value", pred_taken, 0);
        pred(32'h80);
        chk("rbw_updated", pred_taken, 1);

        for (int i = 0; i < 8; i++)
            cyc(0, 1, 32'h80 + 32'(i * 4), 1, 32'h84, i[0], 32'(i) - 32'd3, 3'(i));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/cond_branch_pred.md
Name: cond_branch_pred

Overview:
Branch resolution and prediction unit for the final-project CPU; successor to the purely combinational condition evaluator.
- Evaluates an extended condition set on operand A.
- Keeps a BHT_DEPTH-entry table of 2-bit saturating predictors, indexed by PC.
- Returns a registered prediction at fetch and a registered taken/mispredict result at execute.
- Maintains saturating statistics counters.

Parameters:
N, 32, data width of operand A
PC_W, 32, program counter width
BHT_DEPTH, 16, predictor entries; power of two, >=2; IDX_W = log2(BHT_DEPTH)
INIT_STATE, 2'b01, reset value of every predictor entry (weakly not-taken)
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
pred_req  input  1  fetch-stage prediction request
pred_pc  input  PC_W  PC of the fetched instruction
pred_valid  output  1  prediction valid, one cycle after pred_req
pred_taken  output  1  predicted direction (predictor state MSB)
res_req  input  1  execute-stage resolve request
res_pc  input  PC_W  PC of the resolving branch
res_pred  input  1  direction that was predicted for this branch
A  input  N  condition operand
cond  input  3  condition code
res_valid  output  1  result valid, one cycle after res_req
branch  output  1  resolved taken
mispredict  output  1  branch != res_pred, qualified by res_valid
branch_count  output  CNT_W  conditional branches resolved
mispred_count  output  CNT_W  conditional mispredicts

Behaviour:
- Condition decode, combinational internally:
  - 000 never
  - 100 always
  - 001 A>=0, i.e. ~A[N-1]
  - 010 A<0, i.e. A[N-1]
  - 011 A==0
  - 101 A!=0
  - 110 A>0, i.e. ~A[N-1] & |A
  - 111 reserved, never
  - A is treated as signed two's complement.
- Conditional branch: cond in {001,010,011,101,110}. 000, 100 and 111 are unconditional.
- Index: idx = pc[IDX_W+1:2], word-aligned; bits [1:0] are ignored.
- Prediction, latency 1:
  - On a clk edge with pred_req=1: pred_valid<=1, pred_taken<=bht[idx][1].
  - Otherwise pred_valid<=0; pred_taken holds its last value.
- Resolution, latency 1:
  - On a clk edge with res_req=1: res_valid<=1, branch<=decoded result, mispredict<=(decoded != res_pred).
  - Otherwise res_valid<=0 and mispredict<=0; branch holds.
- Predictor update, same edge as resolution, conditional branches only:
  - Taken: state increments, saturating at 11.
  - Not-taken: state decrements, saturating at 00.
  - Unconditional codes never modify the BHT. They still report mispredict but do not count.
- Counters, conditional branches only:
  - branch_count increments by 1 per conditional resolve.
  - mispred_count increments by 1 per conditional mispredict.
  - Both saturate at all-ones; no wrap.
- Same-cycle pred_req and res_req to the same idx: the prediction returns the pre-update value (read-before-write). The update still takes effect.
- pred_req and res_req are independent and may be asserted every cycle. Back-to-back updates to one entry accumulate, one step per cycle.
- Reset, synchronous:
  - Every BHT entry <= INIT_STATE.
  - pred_valid, pred_taken, res_valid, branch, mispredict <= 0.
  - Both counters <= 0.
  - Reset dominates any request in the same cycle; that request is dropped and does not update the BHT.

Test Plan:
1. Reset, then pred_req pc=0x40 -> next cycle pred_valid=1, pred_taken=0 (INIT 01); all counters 0.
2. res_req pc=0x40, cond=011, A=0, res_pred=0, three times in consecutive cycles:
   - each cycle: branch=1, mispredict=1
   - entry 0x40 goes 01->10->11->11
   - pred_req then gives pred_taken=1
   - branch_count=3, mispred_count=3
3. Condition sweep:
   - A=0xFFFFFFFF: 010->1, 001->0, 110->0, 101->1
   - A=5: 110->1, 011->0
   - 000->0, 111->0, 100->1
4. cond=100 with res_pred=0 -> branch=1, mispredict=1; BHT entry unchanged; branch_count unchanged.
5. Same-cycle pred_req and res_req at pc=0x80 with the entry at 01, cond taken -> pred_taken=0 (old value); following pred_req gives pred_taken=1.
6. Run 2^CNT_W+3 conditional mispredicts (CNT_W overridden to 4) -> both counters stick at 0xF. Then assert rst together with res_req -> counters 0, res_valid=0, BHT back to INIT_STATE.
